// File: rtl/npu_pkg.sv
// Shared defaults, derived widths and FSM encoding for the NPU feed sequencer.
package npu_pkg;

  localparam int LANES_DEF      = 10;
  localparam int PES_DEF        = 16;
  localparam int IN_BEATS_DEF   = 4;
  localparam int OUT_GROUPS_DEF = 5;
  localparam int PIXELS_DEF     = 1024;
  localparam int PIPE_DELAY_DEF = 10;

  // Width of a counter or index for n values; never below one bit.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int PIX_W_DEF = cw(PIXELS_DEF);
  localparam int GRP_W_DEF = cw(OUT_GROUPS_DEF);
  localparam int FA_W_DEF  = cw(PIXELS_DEF * IN_BEATS_DEF);
  localparam int WA_W_DEF  = cw(OUT_GROUPS_DEF * IN_BEATS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/npu_feed_sequencer_if.sv
// RAM read ports, core beat bus and result tags between the sequencer and its neighbours.
interface npu_feed_sequencer_if
  import npu_pkg::*;
#(
  parameter int FA_W  = FA_W_DEF,
  parameter int WA_W  = WA_W_DEF,
  parameter int LANES = LANES_DEF,
  parameter int PES   = PES_DEF,
  parameter int PIX_W = PIX_W_DEF,
  parameter int GRP_W = GRP_W_DEF
) ();

  logic                     fmap_ren;
  logic [FA_W-1:0]          fmap_addr;
  logic [LANES*8-1:0]       fmap_rdata;
  logic                     wt_ren;
  logic [WA_W-1:0]          wt_addr;
  logic [PES*LANES*8-1:0]   wt_rdata;
  logic [LANES*8-1:0]       npu_data;
  logic [PES*LANES*8-1:0]   npu_weight;
  logic                     npu_valid;
  logic                     npu_acc_clr;
  logic                     npu_acc_last;
  logic                     result_valid;
  logic [PIX_W-1:0]         result_pixel;
  logic [GRP_W-1:0]         result_group;

  modport master (
    output fmap_ren, fmap_addr, wt_ren, wt_addr,
    output npu_data, npu_weight, npu_valid, npu_acc_clr, npu_acc_last,
    output result_valid, result_pixel, result_group,
    input  fmap_rdata, wt_rdata
  );

  modport slave (
    input  fmap_ren, fmap_addr, wt_ren, wt_addr,
    input  npu_data, npu_weight, npu_valid, npu_acc_clr, npu_acc_last,
    input  result_valid, result_pixel, result_group,
    output fmap_rdata, wt_rdata
  );

endinterface

// File: rtl/npu_tag_delay.sv
// Cleared shift register of DEPTH stages; DEPTH of zero is a straight wire.
module npu_tag_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  genvar gi;

  if (DEPTH == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_shift
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [W-1:0] stage_d;
      logic [W-1:0] q_reg;

      if (gi == 0) begin : g_head
        assign stage_d = din;
      end else begin : g_tail
        assign stage_d = g_stage[gi-1].q_reg;
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) q_reg <= '0;
        else       q_reg <= stage_d;
      end
    end

    assign dout = g_stage[DEPTH-1].q_reg;
  end

endmodule

// File: rtl/npu_feed_sequencer.sv
// Walks pixel x group x beat for one layer, reads fmap/weight RAMs and feeds the
// core with marked beats; result_valid tracks the core's fixed MAC latency.
module npu_feed_sequencer
  import npu_pkg::*;
#(
  parameter int PIXELS     = PIXELS_DEF,
  parameter int IN_BEATS   = IN_BEATS_DEF,
  parameter int OUT_GROUPS = OUT_GROUPS_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int PES        = PES_DEF,
  parameter int PIPE_DELAY = PIPE_DELAY_DEF,
  parameter int FA_W       = FA_W_DEF,
  parameter int WA_W       = WA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  npu_feed_sequencer_if.master bus
);

  localparam int PIX_W  = cw(PIXELS);
  localparam int GRP_W  = cw(OUT_GROUPS);
  localparam int BEAT_W = cw(IN_BEATS);
  localparam int TAG_W  = 3 + PIX_W + GRP_W;
  localparam int RES_W  = 1 + PIX_W + GRP_W;

  localparam logic [BEAT_W-1:0] B_LAST = BEAT_W'(IN_BEATS - 1);
  localparam logic [GRP_W-1:0]  G_LAST = GRP_W'(OUT_GROUPS - 1);
  localparam logic [PIX_W-1:0]  P_LAST = PIX_W'(PIXELS - 1);

  seq_state_e          state_reg;
  logic                busy_reg, done_reg, ren_reg;
  logic [BEAT_W-1:0]   b_reg, b_next;
  logic [GRP_W-1:0]    g_reg, g_next;
  logic [PIX_W-1:0]    p_reg, p_next;
  logic [FA_W-1:0]     fmap_addr_reg, fmap_addr_next;
  logic [WA_W-1:0]     wt_addr_reg, wt_addr_next;
  logic                beat_wrap, grp_wrap, issue_final;

  always_comb begin
    beat_wrap      = (b_reg == B_LAST);
    grp_wrap       = beat_wrap && (g_reg == G_LAST);
    issue_final    = grp_wrap && (p_reg == P_LAST);
    b_next         = beat_wrap ? '0 : b_reg + 1'b1;
    g_next         = grp_wrap ? '0 : (beat_wrap ? g_reg + 1'b1 : g_reg);
    p_next         = grp_wrap ? ((p_reg == P_LAST) ? '0 : p_reg + 1'b1) : p_reg;
    fmap_addr_next = FA_W'(p_next) * FA_W'(IN_BEATS) + FA_W'(b_next);
    wt_addr_next   = WA_W'(g_next) * WA_W'(IN_BEATS) + WA_W'(b_next);
  end

  // Tags of the address pair on the RAM ports this cycle; markers gated so the
  // counters parked at their last value after the pass never look like a beat.
  logic [TAG_W-1:0] tag_issue, tag_align;
  assign tag_issue = {ren_reg, ren_reg && (b_reg == '0), ren_reg && beat_wrap, p_reg, g_reg};

  npu_tag_delay #(.W(TAG_W), .DEPTH(1)) u_align (
    .clk  (clk),
    .rstn (rstn),
    .din  (tag_issue),
    .dout (tag_align)
  );

  logic             al_valid, al_clr, al_last;
  logic [PIX_W-1:0] al_pix;
  logic [GRP_W-1:0] al_grp;
  assign {al_valid, al_clr, al_last, al_pix, al_grp} = tag_align;

  logic                   npu_valid_reg, acc_clr_reg, acc_last_reg;
  logic [LANES*8-1:0]     npu_data_reg;
  logic [PES*LANES*8-1:0] npu_weight_reg;
  logic [PIX_W-1:0]       beat_pix_reg;
  logic [GRP_W-1:0]       beat_grp_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      npu_valid_reg  <= 1'b0;
      acc_clr_reg    <= 1'b0;
      acc_last_reg   <= 1'b0;
      npu_data_reg   <= '0;
      npu_weight_reg <= '0;
      beat_pix_reg   <= '0;
      beat_grp_reg   <= '0;
    end else begin
      npu_valid_reg <= al_valid;
      acc_clr_reg   <= al_clr;
      acc_last_reg  <= al_last;
      if (al_valid) begin
        npu_data_reg   <= bus.fmap_rdata;
        npu_weight_reg <= bus.wt_rdata;
        beat_pix_reg   <= al_pix;
        beat_grp_reg   <= al_grp;
      end
    end
  end

  logic [RES_W-1:0] res_out;
  logic             res_valid;
  logic [PIX_W-1:0] res_pix;
  logic [GRP_W-1:0] res_grp;

  npu_tag_delay #(.W(RES_W), .DEPTH(PIPE_DELAY)) u_result (
    .clk  (clk),
    .rstn (rstn),
    .din  ({acc_last_reg, beat_pix_reg, beat_grp_reg}),
    .dout (res_out)
  );
  assign {res_valid, res_pix, res_grp} = res_out;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      ren_reg       <= 1'b0;
      b_reg         <= '0;
      g_reg         <= '0;
      p_reg         <= '0;
      fmap_addr_reg <= '0;
      wt_addr_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (start) begin
          state_reg     <= ST_RUN;
          busy_reg      <= 1'b1;
          ren_reg       <= 1'b1;
          b_reg         <= '0;
          g_reg         <= '0;
          p_reg         <= '0;
          fmap_addr_reg <= '0;
          wt_addr_reg   <= '0;
        end
        ST_RUN: if (issue_final) begin
          state_reg <= ST_DRAIN;
          ren_reg   <= 1'b0;
        end else begin
          b_reg         <= b_next;
          g_reg         <= g_next;
          p_reg         <= p_next;
          fmap_addr_reg <= fmap_addr_next;
          wt_addr_reg   <= wt_addr_next;
        end
        // The final group's result is the last thing left in the delay line.
        ST_DRAIN: if (res_valid && res_pix == P_LAST && res_grp == G_LAST) begin
          state_reg <= ST_DONE;
          done_reg  <= 1'b1;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy             = busy_reg;
  assign done             = done_reg;
  assign bus.fmap_ren     = ren_reg;
  assign bus.wt_ren       = ren_reg;
  assign bus.fmap_addr    = fmap_addr_reg;
  assign bus.wt_addr      = wt_addr_reg;
  assign bus.npu_data     = npu_data_reg;
  assign bus.npu_weight   = npu_weight_reg;
  assign bus.npu_valid    = npu_valid_reg;
  assign bus.npu_acc_clr  = acc_clr_reg;
  assign bus.npu_acc_last = acc_last_reg;
  assign bus.result_valid = res_valid;
  assign bus.result_pixel = res_pix;
  assign bus.result_group = res_grp;

endmodule

// File: tb/tb_npu_feed_sequencer.sv
// Scoreboard bench: a small layer (2 px, 4 beats, 2 groups, delay 3) and the default layer.
module tb_npu_feed_sequencer;
  import npu_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start_s = 1'b0;
  logic start_d = 1'b0;
  logic busy_s, done_s, busy_d, done_d;

  int cyc = 0;
  int t0 = 0;
  int checks = 0;
  int errors = 0;
  bit final_req = 1'b0;
  bit final_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  npu_feed_sequencer_if #(.FA_W(4), .WA_W(3), .LANES(2), .PES(2), .PIX_W(1), .GRP_W(1)) bus_s ();
  npu_feed_sequencer_if bus_d ();

  npu_feed_sequencer #(
    .PIXELS(2), .IN_BEATS(4), .OUT_GROUPS(2), .LANES(2), .PES(2),
    .PIPE_DELAY(3), .FA_W(4), .WA_W(3)
  ) u_small (
    .clk(clk), .rstn(rstn), .start(start_s), .busy(busy_s), .done(done_s), .bus(bus_s)
  );

  npu_feed_sequencer u_default (
    .clk(clk), .rstn(rstn), .start(start_d), .busy(busy_d), .done(done_d), .bus(bus_d)
  );

  // Synchronous RAM models: fmap byte0 = addr, byte1 = addr+0x40; weight byte0 = 0x80+addr.
  always @(posedge clk) begin
    if (bus_s.fmap_ren) bus_s.fmap_rdata <= {8'(bus_s.fmap_addr) + 8'h40, 8'(bus_s.fmap_addr)};
    if (bus_s.wt_ren)   bus_s.wt_rdata   <= {{3{8'h5A}}, 8'h80 + 8'(bus_s.wt_addr)};
  end
  assign bus_d.fmap_rdata = '0;
  assign bus_d.wt_rdata   = '0;

  // Hand-computed tables for the small layer.
  localparam int FA_TBL [16] = '{0,1,2,3,0,1,2,3,4,5,6,7,4,5,6,7};
  localparam int WA_TBL [16] = '{0,1,2,3,4,5,6,7,0,1,2,3,4,5,6,7};
  localparam int RES_REL [4] = '{9,13,17,21};
  localparam int RES_PIX [4] = '{0,0,1,1};
  localparam int RES_GRP [4] = '{0,1,0,1};

  typedef struct { int rel; int fa; int wa; } addr_exp_t;
  typedef struct { int rel; int data; int wbyte; bit clr; bit last; } beat_exp_t;
  typedef struct { int rel; int pix; int grp; } res_exp_t;
  typedef struct { int rel; bit busy; int hold; } st_exp_t;

  addr_exp_t addr_q[$];
  beat_exp_t beat_q[$];
  res_exp_t  res_q[$];
  st_exp_t   st_q[$];
  int        done_q[$];

  task automatic push_st(input int rel, input bit busy, input int hold);
    st_exp_t s;
    s.rel = rel; s.busy = busy; s.hold = hold;
    st_q.push_back(s);
  endtask

  task automatic push_small();
    addr_exp_t a;
    beat_exp_t b;
    res_exp_t  r;
    for (int i = 0; i < 16; i++) begin
      a.rel = 1 + i; a.fa = FA_TBL[i]; a.wa = WA_TBL[i];
      addr_q.push_back(a);
      b.rel = 3 + i; b.data = (FA_TBL[i] + 64) * 256 + FA_TBL[i]; b.wbyte = 128 + WA_TBL[i];
      b.clr = (i % 4) == 0; b.last = (i % 4) == 3;
      beat_q.push_back(b);
    end
    for (int i = 0; i < 4; i++) begin
      r.rel = RES_REL[i]; r.pix = RES_PIX[i]; r.grp = RES_GRP[i];
      res_q.push_back(r);
    end
    done_q.push_back(22);
    push_st(0, 1'b0, -1);
    push_st(1, 1'b1, -1);
    push_st(19, 1'b1, 18183);   // data of the last beat (fa=7) held after valid drops
    push_st(21, 1'b1, 18183);
    push_st(22, 1'b1, -1);
    push_st(23, 1'b0, -1);
  endtask

  task automatic goto_rel(input int n);
    while (cyc - t0 < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_small(input bit restart_mid);
    @(posedge clk);
    #1;
    push_small();
    t0 = cyc;
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    if (restart_mid) begin
      goto_rel(8);
      start_s = 1'b1;
      goto_rel(9);
      start_s = 1'b0;
    end
  endtask

  // Default-layer model state.
  int bp = 0, bg = 0, big_res_cnt = 0, big_done_cnt = 0;
  int big_last_p = -1, big_last_g = -1, big_last_cyc = 0;
  int mrel;
  addr_exp_t ea;
  beat_exp_t eb;
  res_exp_t  er;
  st_exp_t   es;
  int        ed;

  always @(negedge clk) begin
    if (final_req && !final_done) begin
      checks++;
      if (addr_q.size() + beat_q.size() + res_q.size() + done_q.size() + st_q.size() != 0) begin
        errors++;
        $display("FAIL leftover: %0d/%0d/%0d/%0d/%0d expected events never seen, required 0",
                 addr_q.size(), beat_q.size(), res_q.size(), done_q.size(), st_q.size());
      end
      checks++;
      if (big_res_cnt != 5120) begin
        errors++;
        $display("FAIL big_count: got %0d result pulses, required 5120", big_res_cnt);
      end
      checks++;
      if (big_done_cnt != 1) begin
        errors++;
        $display("FAIL big_done: got %0d done pulses, required 1", big_done_cnt);
      end
      checks++;
      if (big_last_p != 1023 || big_last_g != 4) begin
        errors++;
        $display("FAIL big_last: got (%0d,%0d), required (1023,4)", big_last_p, big_last_g);
      end
      final_done = 1'b1;
    end

    if (!rstn) begin
      checks++;
      if (|{busy_s, done_s, bus_s.fmap_ren, bus_s.fmap_addr, bus_s.wt_ren, bus_s.wt_addr,
            bus_s.npu_data, bus_s.npu_weight, bus_s.npu_valid, bus_s.npu_acc_clr,
            bus_s.npu_acc_last, bus_s.result_valid, bus_s.result_pixel, bus_s.result_group,
            busy_d, done_d, bus_d.fmap_ren, bus_d.npu_valid, bus_d.result_valid}) begin
        errors++;
        $display("FAIL reset_zero: outputs not all 0 in reset (busy=%b ren=%b fa=%0d valid=%b data=%h), required 0",
                 busy_s, bus_s.fmap_ren, bus_s.fmap_addr, bus_s.npu_valid, bus_s.npu_data);
      end
    end else begin
      mrel = cyc - t0;

      if (bus_s.fmap_ren || bus_s.wt_ren) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL addr_issue: unexpected ren at rel %0d fa=%0d wa=%0d, required none",
                   mrel, bus_s.fmap_addr, bus_s.wt_addr);
        end else begin
          ea = addr_q.pop_front();
          if (!(bus_s.fmap_ren && bus_s.wt_ren) || mrel != ea.rel ||
              int'(bus_s.fmap_addr) != ea.fa || int'(bus_s.wt_addr) != ea.wa) begin
            errors++;
            $display("FAIL addr_issue: got rel=%0d ren=%b/%b fa=%0d wa=%0d, required rel=%0d fa=%0d wa=%0d",
                     mrel, bus_s.fmap_ren, bus_s.wt_ren, bus_s.fmap_addr, bus_s.wt_addr, ea.rel, ea.fa, ea.wa);
          end
        end
      end

      if (bus_s.npu_valid) begin
        checks++;
        if (beat_q.size() == 0) begin
          errors++;
          $display("FAIL beat: unexpected npu_valid at rel %0d, required none", mrel);
        end else begin
          eb = beat_q.pop_front();
          if (mrel != eb.rel || int'(bus_s.npu_data) != eb.data || int'(bus_s.npu_weight[7:0]) != eb.wbyte ||
              bus_s.npu_acc_clr != eb.clr || bus_s.npu_acc_last != eb.last) begin
            errors++;
            $display("FAIL beat: got rel=%0d data=%h w0=%h clr=%b last=%b, required rel=%0d data=%h w0=%h clr=%b last=%b",
                     mrel, bus_s.npu_data, bus_s.npu_weight[7:0], bus_s.npu_acc_clr, bus_s.npu_acc_last,
                     eb.rel, eb.data, eb.wbyte, eb.clr, eb.last);
          end
        end
      end else if (bus_s.npu_acc_clr || bus_s.npu_acc_last) begin
        checks++;
        errors++;
        $display("FAIL beat_marker: clr=%b last=%b without valid at rel %0d, required 0",
                 bus_s.npu_acc_clr, bus_s.npu_acc_last, mrel);
      end

      if (bus_s.result_valid) begin
        checks++;
        if (res_q.size() == 0) begin
          errors++;
          $display("FAIL result: unexpected result_valid at rel %0d, required none", mrel);
        end else begin
          er = res_q.pop_front();
          if (mrel != er.rel || int'(bus_s.result_pixel) != er.pix || int'(bus_s.result_group) != er.grp) begin
            errors++;
            $display("FAIL result: got rel=%0d (%0d,%0d), required rel=%0d (%0d,%0d)",
                     mrel, bus_s.result_pixel, bus_s.result_group, er.rel, er.pix, er.grp);
          end
        end
      end

      if (done_s) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done: unexpected done at rel %0d, required none", mrel);
        end else begin
          ed = done_q.pop_front();
          if (mrel != ed) begin
            errors++;
            $display("FAIL done: got rel=%0d, required rel=%0d", mrel, ed);
          end
        end
      end

      if (st_q.size() > 0 && st_q[0].rel <= mrel) begin
        es = st_q.pop_front();
        checks++;
        if (mrel != es.rel || busy_s != es.busy || (es.hold >= 0 && int'(bus_s.npu_data) != es.hold)) begin
          errors++;
          $display("FAIL status: got rel=%0d busy=%b data=%0d, required rel=%0d busy=%b data=%0d",
                   mrel, busy_s, bus_s.npu_data, es.rel, es.busy, es.hold);
        end
      end

      if ((addr_q.size() > 0 && addr_q[0].rel < mrel) || (beat_q.size() > 0 && beat_q[0].rel < mrel) ||
          (res_q.size() > 0 && res_q[0].rel < mrel) || (done_q.size() > 0 && done_q[0] < mrel)) begin
        checks++;
        errors++;
        $display("FAIL overdue: an expected event did not occur by rel %0d, required on time", mrel);
        if (addr_q.size() > 0 && addr_q[0].rel < mrel) addr_q.delete(0);
        if (beat_q.size() > 0 && beat_q[0].rel < mrel) beat_q.delete(0);
        if (res_q.size() > 0 && res_q[0].rel < mrel) res_q.delete(0);
        if (done_q.size() > 0 && done_q[0] < mrel) done_q.delete(0);
      end

      if (bus_d.result_valid) begin
        checks++;
        if (int'(bus_d.result_pixel) != bp || int'(bus_d.result_group) != bg ||
            (big_res_cnt > 0 && cyc - big_last_cyc != 4)) begin
          errors++;
          $display("FAIL big_result: got #%0d (%0d,%0d) gap=%0d, required (%0d,%0d) gap=4",
                   big_res_cnt, bus_d.result_pixel, bus_d.result_group, cyc - big_last_cyc, bp, bg);
        end
        big_last_p   = int'(bus_d.result_pixel);
        big_last_g   = int'(bus_d.result_group);
        big_last_cyc = cyc;
        big_res_cnt++;
        bg++;
        if (bg == 5) begin
          bg = 0;
          bp++;
        end
      end

      if (done_d) begin
        big_done_cnt++;
        checks++;
        if (cyc - big_last_cyc != 1) begin
          errors++;
          $display("FAIL big_done_timing: done %0d cycles after last result, required 1", cyc - big_last_cyc);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    start_small(1'b0);
    goto_rel(26);

    start_small(1'b1);
    goto_rel(26);

    // Abort a pass at cycle 10, then stay idle with no done and no reads.
    start_small(1'b0);
    goto_rel(10);
    #2;
    rstn = 1'b0;
    addr_q.delete();
    beat_q.delete();
    res_q.delete();
    done_q.delete();
    st_q.delete();
    push_st(30, 1'b0, -1);
    push_st(44, 1'b0, -1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    goto_rel(45);

    start_small(1'b0);
    goto_rel(26);

    @(posedge clk);
    #1;
    start_d = 1'b1;
    @(posedge clk);
    #1;
    start_d = 1'b0;
    for (int k = 0; k < 25000 && !done_d; k++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;

    final_req = 1'b1;
    for (int k = 0; k < 5 && !final_done; k++) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/npu_feed_sequencer.md
Name: npu_feed_sequencer

Overview:
- Upstream stage of the NPU core; owns the convolution loop nest for one layer.
- Walks pixels × output-channel groups × input-channel beats.
- Issues read addresses to the feature-map buffer and the weight buffer (both synchronous RAMs, 1-cycle read latency).
- Forwards the returned words to the core as data/weight beats with valid, accumulator-clear and last markers.
- Generates the result-valid strobe aligned to the core's fixed MAC pipeline latency.

Parameters:
- PIXELS, 1024, feature-map pixels per layer (32×32).
- IN_BEATS, 4, input-channel beats per pixel (40 ch / 10 lanes).
- OUT_GROUPS, 5, output-channel groups (80 ch / 16 PEs).
- LANES, 10, 8-bit input lanes per beat.
- PES, 16, processing elements (output channels per group).
- PIPE_DELAY, 10, cycles from a beat entering the core to its accumulated result appearing at the core output.
- FA_W, 12, fmap address width, ≥ clog2(PIXELS*IN_BEATS).
- WA_W, 5, weight address width, ≥ clog2(OUT_GROUPS*IN_BEATS).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a layer pass when idle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last result is valid
- fmap_ren  out  1  fmap RAM read enable
- fmap_addr  out  FA_W  fmap RAM address
- fmap_rdata  in  LANES*8  fmap RAM data, valid the cycle after fmap_ren
- wt_ren  out  1  weight RAM read enable
- wt_addr  out  WA_W  weight RAM address
- wt_rdata  in  PES*LANES*8  weight RAM data, valid the cycle after wt_ren
- npu_data  out  LANES*8  data beat to core
- npu_weight  out  PES*LANES*8  weight beat to core
- npu_valid  out  1  beat valid (drives both data and weight valid of the core)
- npu_acc_clr  out  1  with the first beat of a group; core restarts accumulation
- npu_acc_last  out  1  with the last beat of a group
- result_valid  out  1  core output holds a completed group result
- result_pixel  out  clog2(PIXELS)  pixel index of the current result
- result_group  out  clog2(OUT_GROUPS)  group index of the current result

Behaviour:
- Reset: every output is 0, FSM in IDLE, counters are 0, delay lines are cleared.
- Reset mid-pass: abandons the pass immediately; no done pulse.
- FSM: IDLE → RUN on start. RUN → DRAIN the cycle after the final address is issued. DRAIN → DONE when the result delay line is empty. DONE → IDLE unconditionally.
- done is high only in DONE. busy is high in RUN, DRAIN and DONE.
- start is ignored outside IDLE.
- RUN loop counters:
  - beat b, 0..IN_BEATS-1 (innermost)
  - group g, 0..OUT_GROUPS-1
  - pixel p, 0..PIXELS-1 (outermost)
  - All counters wrap together; one address pair is issued per cycle with no bubbles.
  - Total issue cycles = PIXELS*OUT_GROUPS*IN_BEATS.
- Address generation, registered outputs:
  - fmap_addr = p*IN_BEATS + b
  - wt_addr = g*IN_BEATS + b
  - fmap_ren and wt_ren are high exactly in the issue cycles.
  - The first address appears the cycle after start is sampled.
- Beat path:
  - Tags (valid, clr = b==0, last = b==IN_BEATS-1, p, g) are delayed 1 cycle to align with rdata.
  - npu_data, npu_weight, npu_valid, npu_acc_clr and npu_acc_last are then registered once more.
  - Net latency: npu_valid is high 2 cycles after the matching ren.
  - npu_data and npu_weight hold their last value when npu_valid is low.
- Result path:
  - result_valid = npu_acc_last delayed PIPE_DELAY cycles.
  - result_pixel and result_group travel in the same delay line.
  - Exactly PIXELS*OUT_GROUPS result_valid pulses per pass, each 1 cycle.
  - Consecutive pulses are IN_BEATS cycles apart.
- DRAIN exits on the cycle the final result_valid is asserted. done follows 1 cycle later.
- Edge case IN_BEATS=1: npu_acc_clr and npu_acc_last are high on every beat.
- Edge case PIPE_DELAY=0: result_valid equals npu_acc_last combinationally-registered, i.e. the same cycle.

Decomposition:
- Package npu_pkg holds:
  - Default LANES, PES, IN_BEATS, OUT_GROUPS, PIXELS
  - The derived widths, via clog2 functions
  - FSM state encoding (IDLE, RUN, DRAIN, DONE)
- Sub-module npu_tag_delay: a parameterised width/depth shift register with asynchronous reset. It is used for both the 1-cycle RAM-alignment delay and the PIPE_DELAY result delay.

Test Plan:
- Small config (PIXELS=2, IN_BEATS=4, OUT_GROUPS=2, PIPE_DELAY=3), start at cycle 0 → 16 ren cycles, cycles 1–16.
  - fmap_addr sequence 0,1,2,3,0,1,2,3,4,5,6,7,4,5,6,7.
  - wt_addr sequence 0..7,0..7.
- Same config with RAM models returning addr-derived data → npu_valid cycles 3–18.
  - npu_data byte0 equals the fmap address issued 2 cycles earlier.
  - npu_acc_clr at cycles 3,7,11,15; npu_acc_last at cycles 6,10,14,18.
- Same config → result_valid at cycles 9,13,17,21.
  - (pixel,group) sequence (0,0),(0,1),(1,0),(1,1).
  - done pulse at cycle 22; busy low from cycle 23.
- start pulsed again at cycle 8 during RUN → ignored; address sequence and result count unchanged.
- rstn asserted at cycle 10 → all outputs 0 asynchronously. After release, no done pulse until a new start; the new pass restarts at address 0.
- Default config → 5120 result_valid pulses; the last one is (1023,4); exactly one done pulse.
